// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read/write side helpers.
package fifo_pkg;

    // Default geometry of the read-side burst packer
    localparam int DATA_WIDTH_DEF = 8;
    localparam int BURST_LEN_DEF  = 4;

    // Width of the debug underflow/overflow event counters
    localparam int UFLOW_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage : fifo_pkg

// File: rtl/fifo_burst_reader_sat_counter.sv
// Saturating event counter with synchronous active-high reset.
// Reused on the FIFO write side for overflow counting.
module sat_counter
    import fifo_pkg::*;
#(
    parameter int WIDTH = UFLOW_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: step on each event, hold once the maximum is reached
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : sat_counter

// File: rtl/fifo_burst_reader.sv
// Read-side consumer for the async FIFO, running in the read-clock domain.
// Pulls BURST_LEN entries, packs them into one wide word and hands the word
// downstream on valid/ready. A flush emits whatever has been collected.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | nothing collected; wait for FIFO data or a pending flush
//   ST_FILL | issuing reads and packing returned entries into slots
//   ST_HOLD | word presented on out_data/out_valid until out_ready
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BURST_LEN  = BURST_LEN_DEF,
    parameter int CNT_W      = 5
) (
    input  logic                            rd_clk,
    input  logic                            rst,
    input  logic                            fifo_empty,
    input  logic [DATA_WIDTH-1:0]           fifo_rdata,
    input  logic                            fifo_valid,
    input  logic                            fifo_underflow,
    output logic                            fifo_rd_en,
    output logic [DATA_WIDTH*BURST_LEN-1:0] out_data,
    output logic [CNT_W-1:0]                out_bytes,
    output logic                            out_valid,
    input  logic                            out_ready,
    input  logic                            flush,
    output logic                            busy,
    output logic [UFLOW_CNT_W-1:0]          underflow_cnt
);

    localparam int               WORD_W    = DATA_WIDTH * BURST_LEN;
    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);

    state_t              state_q,      state_d;
    logic [CNT_W-1:0]    issued_q,     issued_d;
    logic [CNT_W-1:0]    recv_q,       recv_d;
    logic                flush_pend_q, flush_pend_d;
    logic [WORD_W-1:0]   data_q,       data_d;
    logic [CNT_W-1:0]    out_bytes_q,  out_bytes_d;
    logic                out_valid_q,  out_valid_d;
    logic                rd_en;

    // State and datapath registers; reset drops any partially packed word
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            issued_q     <= '0;
            recv_q       <= '0;
            flush_pend_q <= 1'b0;
            data_q       <= '0;
            out_bytes_q  <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            recv_q       <= recv_d;
            flush_pend_q <= flush_pend_d;
            data_q       <= data_d;
            out_bytes_q  <= out_bytes_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // Next-state, read issue and packing logic
    always_comb begin
        state_d      = state_q;
        issued_d     = issued_q;
        recv_d       = recv_q;
        flush_pend_d = flush_pend_q;
        data_d       = data_q;
        out_bytes_d  = out_bytes_q;
        out_valid_d  = out_valid_q;
        rd_en        = 1'b0;

        // A word already in HOLD is being emitted, so a flush there is moot
        if (flush && (state_q != ST_HOLD)) begin
            flush_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty || flush_pend_q) begin
                    state_d = ST_FILL;
                    // Start from a clean word so a short flush leaves
                    // unused slots at zero
                    data_d  = '0;
                end
            end

            ST_FILL: begin
                rd_en = !fifo_empty && (issued_q < BURST_CNT) && !flush_pend_q;
                if (rd_en) begin
                    issued_d = issued_q + CNT_W'(1);
                end

                if (fifo_valid && (recv_q < BURST_CNT)) begin
                    for (int k = 0; k < BURST_LEN; k++) begin
                        if (recv_q == CNT_W'(k)) begin
                            data_d[k*DATA_WIDTH +: DATA_WIDTH] = fifo_rdata;
                        end
                    end
                    recv_d = recv_q + CNT_W'(1);
                end

                // A full word wins over a flush that lands on the last entry
                if (recv_q == BURST_CNT) begin
                    state_d     = ST_HOLD;
                    out_valid_d = 1'b1;
                    out_bytes_d = BURST_CNT;
                end else if (flush_pend_q && (issued_q == recv_q)) begin
                    if (recv_q != '0) begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        out_bytes_d = recv_q;
                    end else begin
                        state_d      = ST_IDLE;
                        flush_pend_d = 1'b0;
                    end
                end
            end

            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    state_d      = ST_IDLE;
                    out_valid_d  = 1'b0;
                    out_bytes_d  = '0;
                    issued_d     = '0;
                    recv_d       = '0;
                    flush_pend_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    sat_counter #(
        .WIDTH (UFLOW_CNT_W)
    ) u_uflow_cnt (
        .clk_i   (rd_clk),
        .rst_i   (rst),
        .inc_i   (fifo_underflow),
        .count_o (underflow_cnt)
    );

    assign fifo_rd_en = rd_en;
    assign out_data   = data_q;
    assign out_bytes  = out_bytes_q;
    assign out_valid  = out_valid_q;
    assign busy       = (state_q != ST_IDLE) || flush_pend_q;

endmodule : fifo_burst_reader
